// File: rtl/scramble_sequencer.sv
// Scramble move initiator for the 4x4 puzzle array: fires NUM_MOVES LFSR-chosen
// row/column moves spaced by GAP_CYCLES, otherwise passes the user controls through.
module scramble_sequencer #(
    parameter int         NUM_MOVES  = 16,
    parameter int         GAP_CYCLES = 1000000,
    parameter logic [7:0] SEED       = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       user_nRow,
    input  logic [3:0] user_row_column,
    input  logic       user_fire,
    output logic       x_nRow,
    output logic [3:0] row_column,
    output logic       fire,
    output logic       busy,
    output logic       done,
    output logic [((NUM_MOVES > 0) ? $clog2(NUM_MOVES + 1) : 1)-1:0] moves_left
);

    localparam int MW = (NUM_MOVES > 0) ? $clog2(NUM_MOVES + 1) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [MW-1:0] MOVES_INIT = MW'(NUM_MOVES);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FIRE, GAP} state_t;

    state_t        state_reg;
    logic [7:0]    lfsr_reg;
    logic [7:0]    lfsr_next;
    logic          mv_nrow_reg;
    logic [3:0]    mv_rc_reg;
    logic [3:0]    mv_rc_next;
    logic [MW-1:0] moves_reg;
    logic [GW-1:0] gap_reg;
    logic          done_reg;

    assign lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

    // The move is taken on the edge that enters LOAD, from the LFSR value that the
    // LOAD cycle will hold, so the select lines are valid for the whole LOAD cycle.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dec
        assign mv_rc_next[gi] = (lfsr_next[1:0] == 2'(gi));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            lfsr_reg    <= SEED;
            mv_nrow_reg <= 1'b0;
            mv_rc_reg   <= 4'b0000;
            moves_reg   <= '0;
            gap_reg     <= '0;
            done_reg    <= 1'b0;
        end else begin
            lfsr_reg <= lfsr_next;
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (NUM_MOVES > 0) begin
                            moves_reg   <= MOVES_INIT;
                            mv_nrow_reg <= lfsr_next[2];
                            mv_rc_reg   <= mv_rc_next;
                            state_reg   <= LOAD;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state_reg <= FIRE;
                end
                FIRE: begin
                    gap_reg   <= GAP_LOAD;
                    state_reg <= GAP;
                end
                GAP: begin
                    if (gap_reg == '0) begin
                        if (moves_reg == MW'(1)) begin
                            moves_reg <= '0;
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            moves_reg   <= moves_reg - MW'(1);
                            mv_nrow_reg <= lfsr_next[2];
                            mv_rc_reg   <= mv_rc_next;
                            state_reg   <= LOAD;
                        end
                    end else begin
                        gap_reg <= gap_reg - GW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Only combinational path: user controls straight through while idle.
    always_comb begin
        busy = (state_reg != IDLE);
        if (busy) begin
            x_nRow     = mv_nrow_reg;
            row_column = mv_rc_reg;
            fire       = (state_reg == FIRE);
        end else begin
            x_nRow     = user_nRow;
            row_column = user_row_column;
            fire       = user_fire;
        end
    end

    assign done       = done_reg;
    assign moves_left = moves_reg;

endmodule

// File: tb/tb_scramble_sequencer.sv
// Bench for scramble_sequencer: a 3-move/gap-4 instance and a zero-move instance
// share stimulus; a cycle-level reference model checks both every cycle.
module tb_scramble_sequencer;

    localparam int         N      = 3;
    localparam int         G      = 4;
    localparam int         P      = G + 2;
    localparam logic [7:0] SEED_A = 8'h01;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       user_nRow = 1'b0;
    logic [3:0] user_rc = 4'b0000;
    logic       user_fire = 1'b0;

    logic       a_xn, a_fire, a_busy, a_done;
    logic [3:0] a_rc;
    logic [1:0] a_ml;
    logic       b_xn, b_fire, b_busy, b_done;
    logic [3:0] b_rc;
    logic [0:0] b_ml;

    int n_cmp = 0;
    int n_bad = 0;
    int rel = 0;
    int fire_at[$];
    int done_at[$];

    scramble_sequencer #(.NUM_MOVES(N), .GAP_CYCLES(G), .SEED(SEED_A)) dut_a (
        .clk(clk), .reset(reset), .start(start), .user_nRow(user_nRow),
        .user_row_column(user_rc), .user_fire(user_fire), .x_nRow(a_xn),
        .row_column(a_rc), .fire(a_fire), .busy(a_busy), .done(a_done),
        .moves_left(a_ml)
    );

    scramble_sequencer #(.NUM_MOVES(0), .GAP_CYCLES(G), .SEED(8'hA5)) dut_b (
        .clk(clk), .reset(reset), .start(start), .user_nRow(user_nRow),
        .user_row_column(user_rc), .user_fire(user_fire), .x_nRow(b_xn),
        .row_column(b_rc), .fire(b_fire), .busy(b_busy), .done(b_done),
        .moves_left(b_ml)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lstep(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Reference model: a scramble is a run of N periods of P cycles, period
    // offset 0 is the setup cycle and offset 1 the fire cycle.
    bit         m_valid = 0;
    bit         m_active = 0;
    bit         m_done = 0;
    bit         mb_done = 0;
    bit         m_nrow = 0;
    logic [3:0] m_rc = 4'b0000;
    logic [7:0] m_lfsr = 8'h00;
    logic [7:0] m_nl;
    int         m_t = 0;
    int         m_ml = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_valid  = 1;
            m_lfsr   = SEED_A;
            m_active = 0;
            m_t      = 0;
            m_ml     = 0;
            m_done   = 0;
            mb_done  = 0;
        end else begin
            m_nl    = lstep(m_lfsr);
            m_done  = 0;
            mb_done = start;
            if (!m_active) begin
                if (start) begin
                    m_active = 1;
                    m_t      = 0;
                    m_ml     = N;
                    m_nrow   = m_nl[2];
                    m_rc     = 4'b0001 << m_nl[1:0];
                end
            end else begin
                m_t++;
                if (m_t % P == 0) begin
                    if (m_ml == 1) begin
                        m_ml     = 0;
                        m_active = 0;
                        m_done   = 1;
                    end else begin
                        m_ml--;
                        m_nrow = m_nl[2];
                        m_rc   = 4'b0001 << m_nl[1:0];
                    end
                end
            end
            m_lfsr = m_nl;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [9:0] ea;
        logic [8:0] eb;
        logic       fa;
        if (!m_valid) return;
        fa = m_active ? (m_t % P == 1) : user_fire;
        ea = {m_active ? m_nrow : user_nRow, m_active ? m_rc : user_rc, fa,
              m_active, m_done, 2'(m_ml)};
        chk("cycle_a", 32'({a_xn, a_rc, a_fire, a_busy, a_done, a_ml}), 32'(ea));
        eb = {user_nRow, user_rc, user_fire, 1'b0, mb_done, 1'b0};
        chk("cycle_b", 32'({b_xn, b_rc, b_fire, b_busy, b_done, b_ml}), 32'(eb));
        if (a_busy) chk("onehot_a", 32'($countones(a_rc)), 32'd1);
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_user();
        user_nRow = 1'($urandom);
        user_rc   = 4'($urandom);
        user_fire = 1'($urandom);
    endtask

    task automatic clear_user();
        user_nRow = 1'b0;
        user_rc   = 4'b0000;
        user_fire = 1'b0;
    endtask

    // Observes n cycles; rel counts cycles since the clear, 0 = cycle after start edge.
    task automatic watch(input int n, input bit rnd);
        for (int j = 0; j < n; j++) begin
            cyc();
            if (a_fire) fire_at.push_back(rel);
            if (a_done) done_at.push_back(rel);
            rel++;
            start = 1'b0;
            if (rnd) rand_user();
        end
    endtask

    task automatic clear_log();
        fire_at.delete();
        done_at.delete();
        rel = 0;
    endtask

    task automatic check_sched(input string nm);
        chk({nm, "_nfire"}, 32'(fire_at.size()), 32'(N));
        for (int i = 0; i < N; i++)
            chk({nm, "_fire_pos"}, 32'((fire_at.size() > i) ? fire_at[i] : -1), 32'(1 + i * P));
        chk({nm, "_ndone"}, 32'(done_at.size()), 32'd1);
        chk({nm, "_done_pos"}, 32'((done_at.size() > 0) ? done_at[0] : -1), 32'(N * P));
        $display("%s: %0d fires, %0d done pulses", nm, fire_at.size(), done_at.size());
    endtask

    typedef struct packed {
        logic       nrow;
        logic [3:0] rc;
        logic       uf;
        logic       e_nrow;
        logic [3:0] e_rc;
        logic       e_fire;
    } vec_t;

    vec_t       vt[6];
    logic [7:0] seed_next;

    initial begin
        vt[0] = '{1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0};
        vt[1] = '{1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1};
        vt[2] = '{1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0};
        vt[3] = '{1'b0, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1};
        vt[4] = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0};
        vt[5] = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1};

        // Reset state.
        repeat (3) cyc();
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_moves", 32'(a_ml), 32'd0);
        reset = 1'b1;

        // Idle passthrough vectors.
        for (int i = 0; i < 6; i++) begin
            user_nRow = vt[i].nrow;
            user_rc   = vt[i].rc;
            user_fire = vt[i].uf;
            #1;
            chk("passthru", 32'({a_xn, a_rc, a_fire}), 32'({vt[i].e_nrow, vt[i].e_rc, vt[i].e_fire}));
            chk("passthru_idle", 32'({a_busy, a_done, a_ml}), 32'd0);
            $display("vec %0d: nRow=%b rc=%b fire=%b -> %b %b %b", i,
                     vt[i].nrow, vt[i].rc, vt[i].uf, a_xn, a_rc, a_fire);
            cyc();
        end
        clear_user();
        cyc();

        // Full scramble with user inputs toggling underneath.
        clear_log();
        start = 1'b1;
        watch(N * P + 1, 1'b1);
        check_sched("scramble_masked");

        // Launched in the done cycle; a start while busy must be ignored.
        clear_user();
        chk("done_cycle", 32'(a_done), 32'd1);
        clear_log();
        start = 1'b1;
        watch(5, 1'b0);
        start = 1'b1;
        watch(N * P + 1 - 5, 1'b0);
        check_sched("scramble_start_busy");

        // Launched coincident with done again.
        clear_log();
        start = 1'b1;
        watch(N * P + 1, 1'b0);
        check_sched("scramble_start_done");

        // Abort in the gap of the second move.
        cyc();
        clear_log();
        start = 1'b1;
        watch(10, 1'b0);
        reset = 1'b0;
        cyc();
        chk("abort_busy", 32'(a_busy), 32'd0);
        reset = 1'b1;
        clear_log();
        watch(25, 1'b0);
        chk("abort_nfire", 32'(fire_at.size()), 32'd0);
        chk("abort_ndone", 32'(done_at.size()), 32'd0);
        $display("abort: %0d fires, %0d done pulses afterwards", fire_at.size(), done_at.size());

        // LFSR restarts from SEED: first move comes from one step past SEED.
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        seed_next = lstep(SEED_A);
        chk("seed_move", 32'({a_xn, a_rc}), 32'({seed_next[2], 4'b0001 << seed_next[1:0]}));
        $display("seed move: nRow=%b rc=%b", a_xn, a_rc);
        clear_log();
        watch(N * P, 1'b0);
        chk("seed_ndone", 32'(done_at.size()), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rand_user();
            start = ($urandom_range(15) == 0);
            reset = ($urandom_range(199) != 0);
            cyc();
        end
        reset = 1'b1;
        start = 1'b0;
        clear_user();
        repeat (N * P + 2) cyc();

        // Zero-move instance: done next cycle, never busy, no fire.
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("nm0_done", 32'(b_done), 32'd1);
        chk("nm0_busy", 32'(b_busy), 32'd0);
        chk("nm0_fire", 32'(b_fire), 32'd0);
        cyc();
        chk("nm0_done_once", 32'(b_done), 32'd0);
        $display("zero-move start: done pulse seen, busy=%b", b_busy);
        repeat (N * P + 2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
